// File: rtl/alu_pkg.sv
// Shared instruction-field layout, ALU control encodings and width defaults
// for the operand-fetch stage and its neighbours.
package alu_pkg;

   localparam int XLEN_D = 32;
   localparam int NREG_D = 32;
   localparam int AW_D   = 5;

   localparam int CTRL_LSB = 0;
   localparam int CTRL_W   = 5;
   localparam int RD_LSB   = 5;
   localparam int RS1_LSB  = 10;
   localparam int RS2_LSB  = 15;

   localparam int CTRL_SIGNED_BIT = 4;
   localparam int CTRL_FLOAT_BIT  = 3;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_MUL = 3'b011,
      OP_DIV = 3'b111
   } alu_op_e;

endpackage

// File: rtl/regfile_2r1w.sv
// NREG x XLEN architectural register file: two combinational read ports,
// one synchronous write port, r0 hardwired to zero, synchronous clear.
module regfile_2r1w
   import alu_pkg::*;
#(
   parameter int XLEN = XLEN_D,
   parameter int NREG = NREG_D,
   parameter int AW   = AW_D
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_we,
   input  logic [AW-1:0]   i_waddr,
   input  logic [XLEN-1:0] i_wdata,
   input  logic [AW-1:0]   i_raddr1,
   output logic [XLEN-1:0] o_rdata1,
   input  logic [AW-1:0]   i_raddr2,
   output logic [XLEN-1:0] o_rdata2
);

   logic [XLEN-1:0] r_mem [NREG];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
      end else if (i_we && (i_waddr != '0)) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_mem[i_raddr1];
   assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_mem[i_raddr2];

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage ahead of the ALU: decodes register fields, reads the
// register file with writeback bypass, stalls on pending destinations.
module alu_operand_stage
   import alu_pkg::*;
#(
   parameter int XLEN = XLEN_D,
   parameter int NREG = NREG_D,
   parameter int AW   = AW_D
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] a,
   output logic [XLEN-1:0] b,
   output logic [31:0]     instruction,
   output logic [AW-1:0]   out_rd
);

   logic [AW-1:0]   w_rs1, w_rs2, w_rd;
   logic [XLEN-1:0] w_rf1, w_rf2, w_op1, w_op2;
   logic            w_byp1, w_byp2, w_hazard, w_accept;
   logic [NREG-1:0] w_pend_nxt;

   logic [NREG-1:0] r_pend;
   logic            r_out_valid;
   logic [XLEN-1:0] r_a, r_b;
   logic [31:0]     r_instr;
   logic [AW-1:0]   r_rd;

   assign w_rs1 = in_instr[RS1_LSB +: AW];
   assign w_rs2 = in_instr[RS2_LSB +: AW];
   assign w_rd  = in_instr[RD_LSB +: AW];

   regfile_2r1w #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rf (
      .clk      (clk),
      .rst      (rst),
      .i_we     (wb_en),
      .i_waddr  (wb_addr),
      .i_wdata  (wb_data),
      .i_raddr1 (w_rs1),
      .o_rdata1 (w_rf1),
      .i_raddr2 (w_rs2),
      .o_rdata2 (w_rf2)
   );

   // A writeback landing this cycle both forwards its data and resolves the hazard.
   assign w_byp1 = wb_en && (wb_addr == w_rs1);
   assign w_byp2 = wb_en && (wb_addr == w_rs2);
   assign w_op1  = (w_rs1 == '0) ? '0 : (w_byp1 ? wb_data : w_rf1);
   assign w_op2  = (w_rs2 == '0) ? '0 : (w_byp2 ? wb_data : w_rf2);

   assign w_hazard = (r_pend[w_rs1] && !w_byp1) || (r_pend[w_rs2] && !w_byp2);
   assign in_ready = !rst && !w_hazard && (!r_out_valid || out_ready);
   assign w_accept = in_valid && in_ready;

   // Set after clear so a newly issued producer wins over an older writeback.
   always_comb begin
      w_pend_nxt = r_pend;
      if (wb_en) w_pend_nxt[wb_addr] = 1'b0;
      if (w_accept && (w_rd != '0)) w_pend_nxt[w_rd] = 1'b1;
      w_pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend      <= '0;
         r_out_valid <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_instr     <= '0;
         r_rd        <= '0;
      end else begin
         r_pend <= w_pend_nxt;
         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_a         <= w_op1;
            r_b         <= w_op2;
            r_instr     <= in_instr;
            r_rd        <= w_rd;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid   = r_out_valid;
   assign a           = r_a;
   assign b           = r_b;
   assign instruction = r_instr;
   assign out_rd      = r_rd;

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Operand-fetch stage sitting directly upstream of the combinational ALU (ports s, ze, a, b, instruction).
- Holds the 32x32 architectural register file and decodes register fields from each incoming instruction word.
- Reads both source operands with bypass from the writeback port and stalls on pending (not yet written back) destinations via a scoreboard.
- Presents a registered a, b and instruction to the ALU under a valid/ready handshake.

Parameters:
XLEN, 32, operand/data width
NREG, 32, number of architectural registers; r0 hardwired to zero
AW, 5, register address width (log2 NREG)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset; synchronous, active-high
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept an instruction this cycle
in_instr  input  32  instruction word: [4:0] ALU control {signed,float,op[2:0]}, [9:5] rd, [14:10] rs1, [19:15] rs2, [31:20] reserved (passed through)
wb_en  input  1  writeback write enable
wb_addr  input  AW  writeback register index
wb_data  input  XLEN  writeback data
out_valid  output  1  a/b/instruction valid to ALU stage
out_ready  input  1  ALU stage consumes this cycle
a  output  XLEN  operand rs1, registered
b  output  XLEN  operand rs2, registered
instruction  output  32  registered copy of in_instr; the ALU uses [4:0]
out_rd  output  AW  registered rd for the downstream writeback

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0; a, b, instruction and out_rd=0; all RF entries=0; all pending bits=0. in_ready=0 while rst=1.
- Read value of rs: 0 if rs==0. Otherwise wb_data if wb_en && wb_addr==rs (same-cycle bypass). Otherwise rf[rs].
- hazard: (pend[rs1] && !(wb_en && wb_addr==rs1)) || (the same term for rs2). pend[0] is always 0.
- in_ready = !rst && !hazard && (!out_valid || out_ready). in_ready is combinational on in_instr, wb_* and out_ready.
- accept = in_valid && in_ready. On accept the next edge loads a, b, instruction and out_rd, and sets out_valid=1. Latency is 1 cycle from accept to out_valid.
- out_valid && out_ready && !accept: out_valid becomes 0.
- out_valid && !out_ready: a, b, instruction and out_rd hold stable. No new accept occurs.
- Back-to-back throughput is 1 instruction/cycle when there is no hazard and out_ready=1.
- RF write: wb_en && wb_addr!=0 writes rf[wb_addr]<=wb_data at the edge. Writes to r0 are ignored.
- Scoreboard (NREG bits):
  - set pend[rd] on accept when rd!=0;
  - clear pend[wb_addr] on wb_en;
  - same index set and cleared in the same cycle: set wins (the newer producer);
  - wb_en to a non-pending register is legal, performs the write, and leaves pend at 0.
- rd equal to rs1/rs2 (e.g. r3=r3+r1): the operand reads the old value (or the bypass), then pend[rd] sets. This is not a hazard for the instruction itself.
- Reset mid-operation: the held output is discarded, the scoreboard is cleared, and the register file returns to 0.
- No arithmetic is performed here. Operand bits pass unchanged; the float/signed interpretation belongs to the ALU.

Decomposition:
- Shared header/package alu_pkg holds:
  - field positions: CTRL[4:0], RD[9:5], RS1[14:10], RS2[19:15];
  - control encodings: SIGNED bit4, FLOAT bit3, OP_ADD 3'b000, OP_SUB 3'b001, OP_MUL 3'b011, OP_DIV 3'b111;
  - XLEN and AW defaults.
- One sub-module, regfile_2r1w: NREG x XLEN, 2 combinational read ports, 1 synchronous write port, r0 reads 0, synchronous reset clear.
- Bypass, scoreboard and output register live in alu_operand_stage.

Test Plan:
1. Reset, wb r1=0x404CCCCD (3.2), wb r2=0xBFA66666 (-1.3), then in_instr rd=3 rs1=1 rs2=2 ctrl=5'b01000 -> one cycle later out_valid=1, a=0x404CCCCD, b=0xBFA66666, instruction[4:0]=01000, out_rd=3.
2. Same-cycle bypass: wb_en r4=0x00000005 on the accept cycle of an instruction with rs1=4 rs2=4 -> a=b=0x00000005; rf[4]=5 afterwards.
3. RAW stall: accept rd=5. The next instruction reads rs1=5 -> in_ready=0 until wb r5=0xFFFFFFFB. It is accepted in that wb cycle, giving a=0xFFFFFFFB; pend[5]=0 afterwards.
4. Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> a/b/instruction/out_rd stable, in_ready=0. out_ready=1 with in_valid=1 -> the next instruction loads on the same edge and out_valid stays 1.
5. r0 rules: wb r0=7, then read rs1=0 -> a=0. An instruction with rd=0 sets no pending bit, so a following rs1=0 instruction issues without stall.
6. Reset mid-op: out_valid=1, pend[5]=1, assert rst one cycle -> out_valid=0. A following rs1=5 instruction issues immediately with a=0.
